zxuno_regbus: RTL
=================

# zxuno_regbus

Controller for the ZX-UNO extended register interface. It decodes CPU I/O cycles on the address port (0xFC3B) and the data port (0xFD3B), and holds the current register number. It generates the read, write and address-change strobes that all register peripherals (core-ID, config, etc.) consume. It also arbitrates the peripherals' read-back data onto the single CPU data return path.

## Interface
- NSRC, 4: number of peripheral read-back sources (1..8).
- ADDR_PORT, 16'hFC3B: I/O address of the register-number port.
- DATA_PORT, 16'hFD3B: I/O address of the register-data port.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- cpu_a  in  16  CPU address bus. Synchronous to clk.
- cpu_din  in  8  CPU write data.
- iorq_n, rd_n, wr_n  in  1 each  CPU control signals. Active-low. Synchronous to clk. clk runs ≥4× the CPU clock.
- zxuno_addr  out  8  current register number.
- zxuno_regrd  out  1  level. High for the whole data-port read cycle.
- zxuno_regwr  out  1  one-cycle write pulse.
- regaddr_changed  out  1  one-cycle pulse after every address-port write.
- regwr_data  out  8  data captured on data-port write. Valid while zxuno_regwr is high and held afterwards.
- periph_dout  in  8*NSRC  read-back data. Source i occupies bits [8i+7:8i].
- periph_oe_n  in  NSRC  active-low read enables from the peripherals.
- dout  out  8  data returned to the CPU.
- oe_n  out  1  low when dout must drive the CPU bus.

## Operation
Cycle detection:
- rd_act = !iorq_n & !rd_n. wr_act = !iorq_n & !wr_n.
- A cycle starts on the clk edge where rd_act or wr_act first becomes 1. Detection uses the registered previous value.
- Only cycles whose cpu_a equals ADDR_PORT or DATA_PORT are handled. All other cycles are ignored; the FSM stays in IDLE.

FSM states: IDLE, ADDR_WR, DATA_RD, DATA_WR, WAIT_END.
- IDLE + start + wr_act + ADDR_PORT → ADDR_WR.
  - Latch zxuno_addr ← cpu_din.
  - Next cycle: regaddr_changed = 1 for exactly one clk.
  - Then → WAIT_END.
- IDLE + start + rd_act + DATA_PORT → DATA_RD.
  - zxuno_regrd = 1 while in DATA_RD.
  - When rd_act drops: → IDLE, and zxuno_regrd falls in the same cycle the FSM leaves DATA_RD.
- IDLE + start + wr_act + DATA_PORT → DATA_WR.
  - Latch regwr_data ← cpu_din.
  - zxuno_regwr = 1 for exactly one clk.
  - Then → WAIT_END.
- IDLE + start + rd_act + ADDR_PORT: no state change. The read-back path returns zxuno_addr.
- WAIT_END → IDLE once rd_act = 0 and wr_act = 0.
- At most one strobe per CPU cycle. A cycle that stays active for many clks never re-strobes.

Read-back path:
- Address-port read active: dout = zxuno_addr, oe_n = 0.
- Data-port read (DATA_RD): dout = periph_dout of the lowest-index source with periph_oe_n = 0, oe_n = 0.
  - If no source is enabled: dout = 8'hFF, oe_n = 1.
- Otherwise: dout = 8'hFF, oe_n = 1.

Simultaneous requests:
- Several sources enabled: lowest index wins. This is a fixed priority, not round-robin.
- rd_act and wr_act both asserted at start: the write takes precedence.

Reset:
- Reset values: zxuno_addr = 8'h00, regwr_data = 8'h00, all strobes 0, FSM = IDLE, dout = 8'hFF, oe_n = 1.
- Reset asserted mid-cycle aborts the cycle; no strobe is emitted.
- After reset releases while a CPU cycle is still active, that cycle is ignored. The edge detector's registered value resets to "active" so no start can be seen until the cycle ends.

## Timing
- Start detected at edge N. The latch (zxuno_addr / regwr_data) updates at edge N.
- zxuno_regwr: high for edge N → N+1.
- regaddr_changed: high for edge N+1 → N+2, so consumers see the new zxuno_addr while the pulse is high.
- zxuno_regrd: high from edge N until the edge after rd_act deasserts.
- dout and oe_n are combinational from the FSM state and peripheral inputs. Peripherals register their own data, giving a total read latency of 1 clk. This is within the CPU I/O read window.

## Structure
- Package zxuno_regbus_pkg holds:
  - port constants 16'hFC3B and 16'hFD3B;
  - the state enum;
  - well-known register numbers (e.g. 8'hFF = core ID).
- Sub-module zxuno_regbus_rdmux: NSRC-way fixed-priority read mux with an idle value of 8'hFF. It is purely combinational; all sequencing stays in the top block.

## Test plan
- Write 8'hFF to 0xFC3B → zxuno_addr = FF, regaddr_changed high exactly 1 clk, the cycle after the latch. Read 0xFC3B → dout = FF, oe_n = 0.
- Write 8'h5A to 0xFD3B with wr_n held low for 6 clks → exactly one zxuno_regwr pulse, regwr_data = 5A, regaddr_changed stays 0.
- Read 0xFD3B with source 2 driving 8'h54 and source 0 idle → zxuno_regrd high for the whole cycle, dout = 54, oe_n = 0. Do 12 successive reads against the core-ID peripheral → the text "T24-25112016" is returned in order.
- Sources 1 and 3 enabled together with 8'h11 / 8'h33 → dout = 11. With no source enabled → dout = FF, oe_n = 1.
- Reset asserted in the middle of a data-port write → no zxuno_regwr pulse, zxuno_addr = 00. The CPU cycle still active after reset release produces no strobe.
- I/O write to 0x00FE and read from 0xFC3A → all strobes stay 0, oe_n = 1.

Source files
------------

// File: rtl/zxuno_regbus_pkg.sv
// Shared constants and types for the ZX-UNO extended register bus controller.
package zxuno_regbus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Default I/O addresses of the register-number and register-data ports
  localparam logic [ADDR_W-1:0] ADDR_PORT_DEF = 16'hFC3B;
  localparam logic [ADDR_W-1:0] DATA_PORT_DEF = 16'hFD3B;

  // Value driven on the return path when nobody answers
  localparam logic [DATA_W-1:0] IDLE_BYTE = 8'hFF;

  // Well-known register numbers
  localparam logic [DATA_W-1:0] REG_COREID = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_WR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_WAIT_END
  } state_e;

endpackage

// File: rtl/zxuno_regbus_if.sv
// CPU-side I/O bus as seen by the register controller.
interface zxuno_regbus_if;
  import zxuno_regbus_pkg::*;

  logic [ADDR_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_din;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic [DATA_W-1:0] dout;
  logic              oe_n;

  modport master (
    output cpu_a, cpu_din, iorq_n, rd_n, wr_n,
    input  dout, oe_n
  );

  modport slave (
    input  cpu_a, cpu_din, iorq_n, rd_n, wr_n,
    output dout, oe_n
  );

endinterface

// File: rtl/zxuno_regbus_rdmux.sv
// Fixed-priority read-back mux: lowest-index enabled source wins.
module zxuno_regbus_rdmux
  import zxuno_regbus_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic                     en,
  input  logic [DATA_W*NSRC-1:0]   src_dout,
  input  logic [NSRC-1:0]          src_oe_n,
  output logic [DATA_W-1:0]        dout_c,
  output logic                     oe_n_c
);

  // Scan from the top index down so the lowest enabled source is applied last
  always_comb begin
    dout_c = IDLE_BYTE;
    oe_n_c = 1'b1;
    if (en) begin
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
        if (!src_oe_n[i]) begin
          dout_c = src_dout[DATA_W*i +: DATA_W];
          oe_n_c = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/zxuno_regbus.sv
// ZX-UNO extended register bus controller: port decode, register number,
// read/write/address-change strobes and peripheral read-back arbitration.
module zxuno_regbus
  import zxuno_regbus_pkg::*;
#(
  parameter int unsigned       NSRC      = 4,
  parameter logic [ADDR_W-1:0] ADDR_PORT = ADDR_PORT_DEF,
  parameter logic [ADDR_W-1:0] DATA_PORT = DATA_PORT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  zxuno_regbus_if.slave          cpu,
  output logic [DATA_W-1:0]      zxuno_addr,
  output logic                   zxuno_regrd,
  output logic                   zxuno_regwr,
  output logic                   regaddr_changed,
  output logic [DATA_W-1:0]      regwr_data,
  input  logic [DATA_W*NSRC-1:0] periph_dout,
  input  logic [NSRC-1:0]        periph_oe_n
);

  logic rd_act, wr_act, act, start, hit_addr, hit_data, addr_rd;

  state_e            state_q, state_d;
  logic              act_q, act_d;
  logic [DATA_W-1:0] zxuno_addr_q, zxuno_addr_d;
  logic [DATA_W-1:0] regwr_data_q, regwr_data_d;
  logic              regwr_q, regwr_d;
  logic              regrd_q, regrd_d;
  logic              addr_chg_q, addr_chg_d;

  logic [DATA_W-1:0] mux_dout;
  logic              mux_oe_n;

  // CPU cycle decode and start-of-cycle edge detection
  always_comb begin
    rd_act   = !cpu.iorq_n && !cpu.rd_n;
    wr_act   = !cpu.iorq_n && !cpu.wr_n;
    act      = rd_act || wr_act;
    start    = act && !act_q;
    hit_addr = (cpu.cpu_a == ADDR_PORT);
    hit_data = (cpu.cpu_a == DATA_PORT);
    addr_rd  = rd_act && !wr_act && hit_addr;
  end

  // Next-state and strobe logic; a write wins when both rd and wr start together
  always_comb begin
    state_d      = state_q;
    act_d        = act;
    zxuno_addr_d = zxuno_addr_q;
    regwr_data_d = regwr_data_q;
    regwr_d      = 1'b0;
    addr_chg_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (wr_act && hit_addr) begin
            state_d      = ST_ADDR_WR;
            zxuno_addr_d = cpu.cpu_din;
          end else if (wr_act && hit_data) begin
            state_d      = ST_DATA_WR;
            regwr_data_d = cpu.cpu_din;
            regwr_d      = 1'b1;
          end else if (rd_act && hit_data) begin
            state_d = ST_DATA_RD;
          end
        end
      end
      ST_ADDR_WR: begin
        addr_chg_d = 1'b1;
        state_d    = ST_WAIT_END;
      end
      ST_DATA_WR:  state_d = ST_WAIT_END;
      ST_DATA_RD:  if (!rd_act) state_d = ST_IDLE;
      ST_WAIT_END: if (!act) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    regrd_d = (state_d == ST_DATA_RD);
  end

  // State and output registers; edge detector resets to "active" to skip an in-flight cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      act_q        <= 1'b1;
      zxuno_addr_q <= '0;
      regwr_data_q <= '0;
      regwr_q      <= 1'b0;
      regrd_q      <= 1'b0;
      addr_chg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      zxuno_addr_q <= zxuno_addr_d;
      regwr_data_q <= regwr_data_d;
      regwr_q      <= regwr_d;
      regrd_q      <= regrd_d;
      addr_chg_q   <= addr_chg_d;
    end
  end

  zxuno_regbus_rdmux #(.NSRC(NSRC)) u_rdmux (
    .en       (regrd_q),
    .src_dout (periph_dout),
    .src_oe_n (periph_oe_n),
    .dout_c   (mux_dout),
    .oe_n_c   (mux_oe_n)
  );

  // Return path: address-port reads echo the register number, else the mux
  always_comb begin
    cpu.dout = addr_rd ? zxuno_addr_q : mux_dout;
    cpu.oe_n = addr_rd ? 1'b0 : mux_oe_n;
  end

  assign zxuno_addr      = zxuno_addr_q;
  assign regwr_data      = regwr_data_q;
  assign zxuno_regwr     = regwr_q;
  assign zxuno_regrd     = regrd_q;
  assign regaddr_changed = addr_chg_q;

endmodule
